// File: rtl/rom_dl_writer.sv
// rom_dl_writer
//   Bridges the HPS ROM-download byte stream onto the SDRAM port1 write channel.
//   Byte pairs are packed little-endian into 16-bit words. The words are
//   buffered in a small FIFO and then written to SDRAM using the toggle req/ack
//   handshake. ioctl_wait throttles the HPS. dl_done pulses once the last word
//   of a download has been acknowledged.
//
//   Optional: define ROM_DL_CHECKSUM_EN to add dl_sum, a 16-bit wrapping sum of
//   every word written. Masked bytes count as zero.
//
// Ports:
//   clk, init_n                 controller clock, async active-low reset
//   ioctl_download/wr/addr/dout HPS download stream (byte address, byte data)
//   ioctl_wait                  back-pressure to HPS
//   port1_req/ack               toggle handshake to SDRAM port1
//   port1_we/a/ds/d             write enable, word address, byte enables, data
//   dl_done                     one-cycle pulse when the download is committed
//   dl_sum                      (ROM_DL_CHECKSUM_EN only) word checksum
module rom_dl_writer #(
  parameter logic [22:0] BASE_WORD  = 23'h000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [23:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port1_we,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
`ifdef ROM_DL_CHECKSUM_EN
  output logic [15:0] dl_sum,
`endif
  output logic        dl_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HI_CNT   = CW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [22:0] addr;
    logic [1:0]  ds;
    logic [15:0] d;
  } ent_t;

  typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

  ent_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  state_t        state;

  logic          dl_q, flush_pending, flush_n;
  logic          held, held_n;
  logic [22:0]   hold_addr, hold_addr_n;
  logic [7:0]    hold_d, hold_d_n;

  logic          push, push_ok, pop, done_cond, dl_fall, byte_ok;
  ent_t          push_ent, head;

  assign dl_fall = dl_q & ~ioctl_download;
  // Bytes of a new download are ignored until the previous one is committed.
  assign byte_ok = ioctl_wr & ioctl_download & ~flush_pending;
  assign head    = mem[rd_ptr];

  // Packer: at most one FIFO push per cycle.
  always_comb begin
    push        = 1'b0;
    push_ent    = '0;
    held_n      = held;
    hold_addr_n = hold_addr;
    hold_d_n    = hold_d;
    if (dl_fall) begin
      if (held) begin
        push     = 1'b1;
        push_ent = {hold_addr, 2'b01, 8'h00, hold_d};
        held_n   = 1'b0;
      end
    end else if (byte_ok) begin
      if (!ioctl_addr[0]) begin
        // A new low byte displaces any byte still waiting for its partner.
        if (held) begin
          push     = 1'b1;
          push_ent = {hold_addr, 2'b01, 8'h00, hold_d};
        end
        held_n      = 1'b1;
        hold_addr_n = ioctl_addr[23:1];
        hold_d_n    = ioctl_dout;
      end else if (held && (hold_addr == ioctl_addr[23:1])) begin
        push     = 1'b1;
        push_ent = {hold_addr, 2'b11, ioctl_dout, hold_d};
        held_n   = 1'b0;
      end else begin
        // A lone high byte goes out alone. Any unrelated held byte stays put.
        push     = 1'b1;
        push_ent = {ioctl_addr[23:1], 2'b10, ioctl_dout, 8'h00};
      end
    end
  end

  assign push_ok   = push && (count != FULL_CNT);
  assign pop       = (state == S_IDLE) && (count != '0);
  assign done_cond = flush_pending && (count == '0) && (state == S_IDLE) &&
                     (port1_ack == port1_req) && !dl_fall;
  assign count_n   = count + CW'(push_ok) - CW'(pop);
  assign flush_n   = dl_fall ? 1'b1 : (done_cond ? 1'b0 : flush_pending);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      dl_q          <= 1'b0;
      flush_pending <= 1'b0;
      held          <= 1'b0;
      hold_addr     <= '0;
      hold_d        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ioctl_wait    <= 1'b0;
      dl_done       <= 1'b0;
      state         <= S_IDLE;
      port1_req     <= 1'b0;
      port1_we      <= 1'b0;
      port1_a       <= '0;
      port1_ds      <= '0;
      port1_d       <= '0;
    end else begin
      dl_q          <= ioctl_download;
      flush_pending <= flush_n;
      held          <= held_n;
      hold_addr     <= hold_addr_n;
      hold_d        <= hold_d_n;
      count         <= count_n;
      // One slot of slack is kept, so a displaced held byte can still be pushed.
      ioctl_wait    <= (count_n >= HI_CNT) || flush_n;
      dl_done       <= done_cond;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);

      case (state)
        S_IDLE: begin
          if (pop) begin
            port1_a   <= BASE_WORD + head.addr;
            port1_ds  <= head.ds;
            port1_d   <= head.d;
            port1_we  <= 1'b1;
            port1_req <= ~port1_req;
            state     <= S_WAIT_ACK;
          end else if (done_cond) begin
            port1_we  <= 1'b0;
          end
        end
        S_WAIT_ACK: begin
          if (port1_ack == port1_req) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)
      dl_sum <= '0;
    else if (ioctl_download && !dl_q)
      dl_sum <= '0;
    else if (pop)
      dl_sum <= dl_sum + (head.d & {{8{head.ds[1]}}, {8{head.ds[0]}}});
  end
`endif

endmodule

// File: tb/tb_rom_dl_writer.sv
module tb_rom_dl_writer;
  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [23:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait, port1_req, port1_we, dl_done;
  logic        port1_ack = 1'b0;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        wait2, req2, we2, done2;
  logic        ack2 = 1'b0;
  logic [22:0] a2;
  logic [1:0]  ds2;
  logic [15:0] d2;
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] dl_sum, dl_sum2;
`endif

  int  checks = 0, errors = 0;
  wr_t exp_q[$], q2[$];
  wr_t cur, e_w;
  int  ack_dly = 3, cnt = 0, done_cnt = 0, issued = 0;
  bit  busy = 0, req_seen = 0, req2_seen = 0, wait_seen = 0;

  always #5 clk = ~clk;

  rom_dl_writer dut (
    .clk(clk), .init_n(init_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_we(port1_we),
    .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
`ifdef ROM_DL_CHECKSUM_EN
    .dl_sum(dl_sum),
`endif
    .dl_done(dl_done)
  );

  rom_dl_writer #(.BASE_WORD(23'h100000)) dut2 (
    .clk(clk), .init_n(init_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(wait2),
    .port1_req(req2), .port1_ack(ack2), .port1_we(we2),
    .port1_a(a2), .port1_ds(ds2), .port1_d(d2),
`ifdef ROM_DL_CHECKSUM_EN
    .dl_sum(dl_sum2),
`endif
    .dl_done(done2)
  );

  // SDRAM model + scoreboard for the main DUT.
  always @(negedge clk) begin
    if (!init_n) begin
      port1_ack = 1'b0;
      req_seen  = 1'b0;
      busy      = 1'b0;
    end else begin
      if (ioctl_wait) wait_seen = 1'b1;
      if (port1_req !== req_seen) begin
        req_seen = port1_req;
        issued++;
        cur = {port1_a, port1_ds, port1_d};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got a=%h ds=%b d=%h, required no write",
                   port1_a, port1_ds, port1_d);
        end else begin
          e_w = exp_q.pop_front();
          if (cur !== e_w || port1_we !== 1'b1) begin
            errors++;
            $display("FAIL write: got a=%h ds=%b d=%h we=%b, required a=%h ds=%b d=%h we=1",
                     port1_a, port1_ds, port1_d, port1_we, e_w.a, e_w.ds, e_w.d);
          end
        end
        busy = 1'b1;
        cnt  = ack_dly;
      end else if (busy) begin
        checks++;
        if ({port1_a, port1_ds, port1_d} !== cur) begin
          errors++;
          $display("FAIL write_stable: got %h, required %h", {port1_a, port1_ds, port1_d}, cur);
        end
        cnt--;
        if (cnt <= 0) begin
          port1_ack = port1_req;
          busy = 1'b0;
        end
      end
      if (dl_done) begin
        done_cnt++;
        checks++;
        if (exp_q.size() != 0 || busy || port1_ack !== port1_req) begin
          errors++;
          $display("FAIL done_early: got pending=%0d busy=%0d, required 0 0", exp_q.size(), busy);
        end
      end
    end
  end

  // Fast-ack model for the offset-base instance; it only captures writes.
  always @(negedge clk) begin
    if (!init_n) begin
      ack2      = 1'b0;
      req2_seen = 1'b0;
    end else if (req2 !== req2_seen) begin
      req2_seen = req2;
      q2.push_back({a2, ds2, d2});
      ack2 = req2;
    end
  end

  task automatic send_byte(input logic [23:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (ioctl_wait === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: got ioctl_wait=%b, required 0", ioctl_wait);
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt == start) begin
      errors++;
      $display("FAIL %s_done_timeout: got no dl_done in %0d cycles, required pulse", name, budget);
    end
    @(negedge clk);
  endtask

  task automatic dl_start();
    @(negedge clk);
    ioctl_download = 1'b1;
  endtask

  task automatic dl_end();
    @(negedge clk);
    ioctl_download = 1'b0;
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ioctl_wait, port1_req, port1_we, port1_a, port1_ds, port1_d, dl_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wait=%b req=%b we=%b a=%h ds=%b d=%h done=%b, required all 0",
               ioctl_wait, port1_req, port1_we, port1_a, port1_ds, port1_d, dl_done);
    end
    init_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int d0;
    ack_dly = 3;
    d0 = done_cnt;
    exp_q.push_back({23'h0, 2'b11, 16'h2211});
    exp_q.push_back({23'h1, 2'b11, 16'h4433});
    dl_start();
    send_byte(24'h0, 8'h11);
    send_byte(24'h1, 8'h22);
    send_byte(24'h2, 8'h33);
    send_byte(24'h3, 8'h44);
    dl_end();
    wait_done(200, "basic");
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_done_count: got %0d pulses %0d pending, required 1 0", done_cnt - d0, exp_q.size());
    end
    checks++;
    if (port1_we !== 1'b0 || ioctl_wait !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got we=%b wait=%b, required 0 0", port1_we, ioctl_wait);
    end
  endtask

  task automatic test_odd_length();
    exp_q.push_back({23'h0, 2'b11, 16'hBBAA});
    exp_q.push_back({23'h1, 2'b01, 16'h00CC});
    dl_start();
    send_byte(24'h0, 8'hAA);
    send_byte(24'h1, 8'hBB);
    send_byte(24'h2, 8'hCC);
    dl_end();
    wait_done(200, "odd");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL odd_pending: got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_unpaired();
    int i0;
    i0 = issued;
    // Strobe while no download is active must be ignored.
    @(negedge clk);
    ioctl_addr = 24'h0; ioctl_dout = 8'hEE; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (issued != i0) begin
      errors++;
      $display("FAIL wr_no_download: got %0d writes, required 0", issued - i0);
    end
    exp_q.push_back({23'h0, 2'b10, 16'h0100});
    exp_q.push_back({23'h2, 2'b01, 16'h0002});
    exp_q.push_back({23'h4, 2'b10, 16'h0400});
    exp_q.push_back({23'h3, 2'b01, 16'h0003});
    dl_start();
    send_byte(24'h1, 8'h01);
    send_byte(24'h4, 8'h02);
    send_byte(24'h6, 8'h03);
    send_byte(24'h9, 8'h04);
    dl_end();
    wait_done(300, "unpaired");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL unpaired_pending: got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    int pushed, i0;
    logic exp_wait;
    logic [7:0] lo, hi;
    ack_dly = 40;
    wait_seen = 1'b0;
    pushed = 0;
    i0 = issued;
    dl_start();
    for (int i = 0; i < 8; i++) begin
      lo = 8'(i * 16 + 1);
      hi = 8'(i * 16 + 2);
      exp_q.push_back({23'(i), 2'b11, hi, lo});
      send_byte(24'(2 * i), lo);
      send_byte(24'(2 * i + 1), hi);
      pushed++;
      #1;
      exp_wait = ((pushed - (issued - i0)) >= 3);
      checks++;
      if (ioctl_wait !== exp_wait) begin
        errors++;
        $display("FAIL bp_wait word %0d: got %b, required %b", i, ioctl_wait, exp_wait);
      end
    end
    dl_end();
    wait_done(2000, "bp");
    checks++;
    if (wait_seen !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_result: got wait_seen=%b pending=%0d, required 1 0", wait_seen, exp_q.size());
    end
    ack_dly = 3;
  endtask

  task automatic test_base_word();
    q2.delete();
    exp_q.push_back({23'h000008, 2'b01, 16'h005A});
    exp_q.push_back({23'h7FFFFF, 2'b01, 16'h0077});
    dl_start();
    send_byte(24'h000010, 8'h5A);
    send_byte(24'hFFFFFE, 8'h77);
    dl_end();
    wait_done(200, "base");
    repeat (4) @(negedge clk);
    checks++;
    if (q2.size() != 2) begin
      errors++;
      $display("FAIL base_count: got %0d writes, required 2", q2.size());
    end else begin
      checks++;
      if (q2[0] !== {23'h100008, 2'b01, 16'h005A}) begin
        errors++;
        $display("FAIL base_offset: got %h, required %h", q2[0], {23'h100008, 2'b01, 16'h005A});
      end
      checks++;
      if (q2[1] !== {23'h0FFFFF, 2'b01, 16'h0077}) begin
        errors++;
        $display("FAIL base_wrap: got %h, required %h", q2[1], {23'h0FFFFF, 2'b01, 16'h0077});
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    ack_dly = 40;
    exp_q.push_back({23'h0, 2'b11, 16'h2211});
    dl_start();
    send_byte(24'h0, 8'h11);
    send_byte(24'h1, 8'h22);
    n = 0;
    while (!busy && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    init_n = 1'b0;
    #1;
    checks++;
    if ({ioctl_wait, port1_req, port1_we, port1_a, port1_ds, port1_d, dl_done} !== '0 || n >= 100) begin
      errors++;
      $display("FAIL reset_async: got req=%b we=%b a=%h ds=%b d=%h (busy wait %0d), required all 0",
               port1_req, port1_we, port1_a, port1_ds, port1_d, n);
    end
    exp_q.delete();
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk);
    init_n = 1'b1;
    ack_dly = 3;
    exp_q.push_back({23'h0, 2'b11, 16'h3CC3});
    dl_start();
    send_byte(24'h0, 8'hC3);
    send_byte(24'h1, 8'h3C);
    dl_end();
    wait_done(200, "post_reset");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_pending: got %0d, required 0", exp_q.size());
    end
  endtask

`ifdef ROM_DL_CHECKSUM_EN
  task automatic test_checksum();
    exp_q.push_back({23'h0, 2'b11, 16'hFFFF});
    exp_q.push_back({23'h1, 2'b11, 16'h0002});
    dl_start();
    send_byte(24'h0, 8'hFF);
    send_byte(24'h1, 8'hFF);
    send_byte(24'h2, 8'h02);
    send_byte(24'h3, 8'h00);
    dl_end();
    wait_done(200, "sum");
    checks++;
    if (dl_sum !== 16'h0001) begin
      errors++;
      $display("FAIL checksum: got %h, required 0001", dl_sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_unpaired();
    test_back_pressure();
    test_base_word();
    test_reset_mid();
`ifdef ROM_DL_CHECKSUM_EN
    test_checksum();
`endif
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rom_dl_writer.md
Name: rom_dl_writer

Overview:
- Sits directly upstream of the SDRAM controller's port1 write channel.
- Accepts the HPS ROM-download byte stream (ioctl_*), packs byte pairs into 16-bit words and buffers them in a small FIFO.
- Drains the FIFO into SDRAM using the toggle req/ack handshake, and back-pressures the download with ioctl_wait.
- Signals completion after the last word has been acknowledged.

Parameters:
- BASE_WORD, 23'h000000, SDRAM word address added to ioctl_addr[23:1].
- FIFO_DEPTH, 4, word FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  SDRAM clock (same as controller clock)
- init_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  high while a ROM download is active
- ioctl_wr  in  1  one-cycle strobe, byte valid
- ioctl_addr  in  24  byte address of ioctl_dout
- ioctl_dout  in  8  download byte
- ioctl_wait  out  1  back-pressure to HPS
- port1_req  out  1  toggle request to SDRAM port1
- port1_ack  in  1  equals port1_req when the write has completed
- port1_we  out  1  constant 1 while this block owns the port
- port1_a  out  23  word address
- port1_ds  out  2  byte enables, bit0 = [7:0], bit1 = [15:8]
- port1_d  out  16  write data
- dl_done  out  1  one-cycle pulse when download fully committed

Behaviour:
- Reset (init_n low, asynchronous) clears all outputs and internal state:
  - ioctl_wait=0, port1_req=0, port1_we=0, port1_a=0, port1_ds=0, port1_d=0, dl_done=0.
  - FIFO empty, packer empty, FSM in IDLE.
- Byte packing is little-endian:
  - Even ioctl_addr[0] byte → low half; held in the packer with hold_addr=ioctl_addr[23:1].
  - Odd byte → high half; if its ioctl_addr[23:1] equals hold_addr, the word is pushed with ds=2'b11.
  - Odd byte with no matching held even byte → pushed alone with ds=2'b10.
  - Even byte arriving while the packer already holds a byte → first push the held byte with ds=2'b01, then hold the new byte. This takes 1 cycle and is allowed because ioctl_wait guards capacity.
- FIFO entry = {addr[23:1], ds[1:0], d[15:0]}; count width $clog2(FIFO_DEPTH)+1.
- ioctl_wait = (count >= FIFO_DEPTH-1) || flush_pending. It is registered and updates the cycle after a push or pop.
- A push into a full FIFO is a protocol violation: data is dropped, and the behaviour is undefined beyond that. The bench asserts this never happens.
- Drain FSM:
  - IDLE: if FIFO is non-empty, pop the head and load port1_a = BASE_WORD + addr, port1_ds, port1_d. Set port1_we=1, toggle port1_req, go to WAIT_ACK.
  - WAIT_ACK: hold all port1 outputs stable. When port1_ack == port1_req, go to IDLE. The next request may toggle on the cycle after ack is seen, giving one request per ack.
  - Address arithmetic is modulo 2^23 (wraps).
- Download end (falling edge of ioctl_download):
  - Set flush_pending. If the packer holds a byte, push it with ds=2'b01.
  - When the FIFO is empty and the FSM is in IDLE with ack == req: pulse dl_done for 1 cycle, clear flush_pending, set port1_we=0.
- ioctl_download rising while flush_pending: the new download's bytes are accepted only after dl_done. ioctl_wait stays high until then.
- Simultaneous push and pop in one cycle: count is unchanged, and both operations take effect.
- ioctl_wr while ioctl_download=0: ignored.
- Reset mid-transfer: the FSM aborts and req returns to 0. The controller's req/ack state is also reset by the top level, so no dangling request remains.

Optional Feature:
- Macro ROM_DL_CHECKSUM_EN.
- When defined:
  - Adds output dl_sum [15:0]: the 16-bit wrapping sum of every word d actually written, with masked bytes counted as 0.
  - Cleared at ioctl_download rising edge; valid and stable from dl_done until the next download.
- When undefined: the port and adder are absent, and there is no other change.

Test Plan:
- Bytes 0x11@0, 0x22@1, 0x33@2, 0x44@3; ack returned 3 cycles after each req toggle → two writes: a=0 d=0x2211 ds=11, then a=1 d=0x4433 ds=11. dl_done fires once, after the second ack.
- Odd length: bytes 0xAA@0, 0xBB@1, 0xCC@2, then download falls → third write a=1 d=0x00CC ds=01, followed by dl_done.
- Back-pressure: ack withheld 40 cycles, HPS honours ioctl_wait, 16 bytes sent → ioctl_wait rises when count reaches 3. There is no overflow, and the 8 writes are issued in address order.
- BASE_WORD=23'h100000, byte 0x5A@24'h000010 → port1_a=23'h100008, ds=01 at flush.
- Reset asserted while in WAIT_ACK → all outputs are 0 immediately (asynchronously). After release, a new 2-byte download writes correctly from a=0.
- With ROM_DL_CHECKSUM_EN, words 0xFFFF and 0x0002 → dl_sum=0x0001 at dl_done.
